prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter ERR_CNT_W, default 16, width of the error counter.
REQ-002 Parameter LOCK_WIN, default 64, window length in valid bits for the lock and loss decisions.
REQ-003 Parameter LOSS_THRESH, default 8, number of errors inside one window that forces resync.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 en  input  1  checker enable; 0 forces IDLE.
REQ-007 rst_prbs  input  1  synchronous clear; zeroes counters and forces resync.
REQ-008 prbs_sel  input  1  0 = PRBS-7 (x^7+x^6+1), 1 = PRBS-15 (x^15+x^14+1).
REQ-009 din  input  1  received serial bit (deserialized dout_p/dout_n stream).
REQ-010 din_valid  input  1  din is qualified this cycle.
REQ-011 lock  output  1  checker synchronized to the sequence.
REQ-012 err_pulse  output  1  one-cycle flag for a bit mismatch while in CHECK.
REQ-013 err_cnt  output  ERR_CNT_W  saturating count of mismatches while locked.
REQ-014 bit_cnt  output  32  saturating count of valid bits compared while locked.

Function
REQ-015 States: IDLE, SEED, CHECK; all state changes occur only on cycles with din_valid=1, except those caused by en and rst_prbs.
REQ-016 IDLE: when en=1, sample prbs_sel into an internal register, clear the seed count, then go to SEED on the next cycle.
REQ-017 SEED: each valid bit shifts into the LFSR (s <= {s[13:0],din}); after N valid bits (N=7 or 15) go to CHECK.
REQ-018 CHECK: predicted bit p = s[6]^s[5] (PRBS-7) or s[14]^s[13] (PRBS-15); the LFSR shifts in p, not din, so one flipped bit gives exactly one error.
REQ-019 A mismatch (din!=p) on a valid cycle sets err_pulse=1 on the following cycle only.
REQ-020 Window counter counts valid bits in CHECK modulo LOCK_WIN; errors in the current window are counted separately.
REQ-021 lock rises at the end of the first complete window with zero errors.
REQ-022 A window error count reaching LOSS_THRESH drops lock on the next cycle, with transition to SEED; counters hold.
REQ-023 err_cnt and bit_cnt increment only while lock=1, and saturate at all-ones without wrapping.
REQ-024 rst_prbs=1: next cycle err_cnt=0, bit_cnt=0, lock=0, err_pulse=0, state=SEED; it has priority over a simultaneous din_valid.
REQ-025 en=0: next cycle state=IDLE, lock=0, err_pulse=0; err_cnt and bit_cnt hold their values.
REQ-026 A prbs_sel change takes effect only at the next entry to IDLE or SEED.
REQ-027 din_valid=0 cycles are ignored entirely: no shift, no count, no compare.

Reset
REQ-028 rst_n=0 at a rising edge sets state=IDLE, LFSR=0, lock=0, err_pulse=0, err_cnt=0, bit_cnt=0, window and seed counters=0.
REQ-029 Reset takes priority over rst_prbs and en and aborts any operation in progress.

Structure
REQ-030 Package prbs_pkg holds the state enum, the PRBS-7/15 tap constants and the order constants 7/15; the generator uses the same package.
REQ-031 The LFSR next-bit logic is a sub-module prbs_lfsr_step (combinational, polynomial select) shared with the generator.

Verification
REQ-032 PRBS-7 stream, seed 7'h7F, continuous valid -> lock=1 at 7+64 valid bits after SEED entry; err_cnt=0 after 1000 bits.
REQ-033 Locked PRBS-15, one bit flipped (inj_error) -> exactly one err_pulse cycle; err_cnt=1; lock stays 1.
REQ-034 Locked, 8 flips within 64 bits -> lock=0 and state=SEED; clean stream resumes -> relock after 15+64 bits.
REQ-035 din_valid toggling 1/0 on alternate cycles, PRBS-7 -> identical lock timing counted in valid bits; no spurious errors.
REQ-036 ERR_CNT_W=4, continuous errors while forced locked -> err_cnt holds at 4'hF; rst_prbs plus din_valid in the same cycle -> counters 0, state=SEED.
REQ-037 rst_n low for one cycle mid-CHECK -> all outputs 0 on the next cycle; state=IDLE.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS-7/PRBS-15 constants, checker state type and order helper
package prbs_pkg;
  typedef enum logic [1:0] {IDLE, SEED, CHECK} state_t;
  localparam int PRBS_W = 15;
  localparam int PRBS7_ORDER = 7;
  localparam int PRBS15_ORDER = 15;
  localparam logic [PRBS_W-1:0] PRBS7_TAPS = 15'h0060;
  localparam logic [PRBS_W-1:0] PRBS15_TAPS = 15'h6000;
  function automatic logic [3:0] prbs_order(input logic sel);
    return sel ? 4'(PRBS15_ORDER) : 4'(PRBS7_ORDER);
  endfunction
endpackage

// File: rtl/prbs_lfsr_step.sv
// prbs_lfsr_step: feedback bit of the PRBS-7/PRBS-15 Fibonacci LFSR (s[0] is newest)
module prbs_lfsr_step import prbs_pkg::*; (
  input  logic [PRBS_W-1:0] s,
  input  logic              sel,
  output logic              p
);
  assign p = ^(s & (sel ? PRBS15_TAPS : PRBS7_TAPS));
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronizing PRBS-7/15 checker with windowed lock/loss and saturating counters
module prbs_checker import prbs_pkg::*; #(
  parameter int ERR_CNT_W   = 16,
  parameter int LOCK_WIN    = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rst_prbs,
  input  logic                 prbs_sel,
  input  logic                 din,
  input  logic                 din_valid,
  output logic                 lock,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [31:0]          bit_cnt
);
  localparam int WW = $clog2(LOCK_WIN + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);
  state_t state, state_nx;
  logic [PRBS_W-1:0] s;
  logic sel, p, chk, mis, win_end, loss, seed_done, restart;
  logic [3:0] seed_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err;
  prbs_lfsr_step u_step (.s(s), .sel(sel), .p(p));
  assign chk = din_valid && state == CHECK;
  assign mis = chk && din != p;
  assign win_end = chk && win_cnt == WW'(LOCK_WIN - 1);
  assign loss = mis && win_err == EW'(LOSS_THRESH - 1);
  assign seed_done = din_valid && state == SEED && seed_cnt == prbs_order(sel) - 4'd1;
  // any (re)entry to SEED or IDLE resamples prbs_sel and clears the sync counters
  assign restart = !en || rst_prbs || state == IDLE || loss;
  always_comb begin
    state_nx = !en ? IDLE : (rst_prbs || state == IDLE || loss) ? SEED : seed_done ? CHECK : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s         <= '0;
      sel       <= 1'b0;
      seed_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      lock      <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      err_pulse <= en && !rst_prbs && mis;
      if (rst_prbs) begin
        err_cnt <= '0;
        bit_cnt <= '0;
      end else if (en && lock && chk) begin
        err_cnt <= (mis && ~&err_cnt) ? err_cnt + 1'b1 : err_cnt;
        bit_cnt <= ~&bit_cnt ? bit_cnt + 1'b1 : bit_cnt;
      end
      if (restart) begin
        lock     <= 1'b0;
        sel      <= prbs_sel;
        seed_cnt <= '0;
        win_cnt  <= '0;
        win_err  <= '0;
      end else if (din_valid && state == SEED) begin
        s        <= {s[PRBS_W-2:0], din};
        seed_cnt <= seed_cnt + 1'b1;
      end else if (chk) begin
        s       <= {s[PRBS_W-2:0], p};
        win_cnt <= win_end ? '0 : win_cnt + 1'b1;
        win_err <= win_end ? '0 : win_err + EW'(mis);
        if (win_end && !mis && win_err == '0) lock <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: randomized scoreboard bench against a sequence-level reference model
module tb_prbs_checker;
  localparam int EW = 4, WIN = 64, THR = 8;
  logic clk = 1'b0;
  logic rst_n, en, rst_prbs, prbs_sel, din, din_valid;
  logic lock, err_pulse;
  logic [EW-1:0] err_cnt;
  logic [31:0] bit_cnt;
  typedef struct { bit lock; bit pulse; int err; logic [31:0] bits; } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  int ph, win_bits, win_errs, m_err;
  bit m_lock, m_pulse, m_sel, gsel;
  logic [31:0] m_bits;
  bit hist[$];
  bit g[$];

  always #5 clk = ~clk;

  prbs_checker #(.ERR_CNT_W(EW), .LOCK_WIN(WIN), .LOSS_THRESH(THR)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rst_prbs(rst_prbs), .prbs_sel(prbs_sel),
    .din(din), .din_valid(din_valid), .lock(lock), .err_pulse(err_pulse),
    .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  function automatic int ord(input bit s);
    return s ? 15 : 7;
  endfunction

  task automatic restart();
    ph = 1;
    m_sel = prbs_sel;
    hist.delete();
    win_bits = 0;
    win_errs = 0;
    m_lock = 0;
  endtask

  // reference: hist holds the last N reference bits, next bit = a[k-N] ^ a[k-N+1]
  task automatic model_step();
    bit p, miss;
    if (!rst_n) begin
      ph = 0; m_lock = 0; m_pulse = 0; m_err = 0; m_bits = '0;
      win_bits = 0; win_errs = 0; hist.delete();
      return;
    end
    m_pulse = 0;
    if (rst_prbs) begin m_err = 0; m_bits = '0; end
    if (!en) begin ph = 0; m_lock = 0; return; end
    if (rst_prbs || ph == 0) begin restart(); return; end
    if (!din_valid) return;
    if (ph == 1) begin
      hist.push_back(din);
      if (hist.size() == ord(m_sel)) ph = 2;
      return;
    end
    p = hist[0] ^ hist[1];
    hist.push_back(p);
    void'(hist.pop_front());
    miss = din != p;
    m_pulse = miss;
    if (m_lock) begin
      if (m_bits != 32'hFFFF_FFFF) m_bits = m_bits + 1;
      if (miss && m_err < (1 << EW) - 1) m_err++;
    end
    win_bits++;
    win_errs += int'(miss);
    if (win_errs == THR) restart();
    else if (win_bits == WIN) begin
      if (win_errs == 0) m_lock = 1;
      win_bits = 0;
      win_errs = 0;
    end
  endtask

  task automatic gen_seed(input logic [14:0] seed);
    g.delete();
    for (int i = 14; i >= 0; i--) g.push_back(seed[i]);
  endtask

  task automatic gen_bit(output bit b);
    b = g[15 - ord(gsel)] ^ g[16 - ord(gsel)];
    g.push_back(b);
    void'(g.pop_front());
  endtask

  task automatic step(input bit v, input bit flip);
    bit b;
    b = 0;
    if (v) gen_bit(b);
    din_valid = v;
    din = v ? (b ^ flip) : 1'($urandom_range(0, 1));
    model_step();
    @(posedge clk);
    q.push_back('{m_lock, m_pulse, m_err, m_bits});
    #1;
  endtask

  task automatic pulse_rst_prbs(input bit v);
    rst_prbs = 1;
    step(v, 0);
    rst_prbs = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (lock !== e.lock) begin
        miscompares++;
        $display("FAIL lock: got %b expected %b at %0t", lock, e.lock, $time);
      end
      if (err_pulse !== e.pulse) begin
        miscompares++;
        $display("FAIL err_pulse: got %b expected %b at %0t", err_pulse, e.pulse, $time);
      end
      if (err_cnt !== EW'(e.err)) begin
        miscompares++;
        $display("FAIL err_cnt: got %0d expected %0d at %0t", err_cnt, e.err, $time);
      end
      if (bit_cnt !== e.bits) begin
        miscompares++;
        $display("FAIL bit_cnt: got %0d expected %0d at %0t", bit_cnt, e.bits, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 0; en = 0; rst_prbs = 0; prbs_sel = 0; din = 0; din_valid = 0; gsel = 0;
    gen_seed(15'h007F);
    #1;
    repeat (3) step(0, 0);
    rst_n = 1;
    step(1, 0);
    // PRBS-7 from seed 7F, continuous valid
    en = 1;
    step(0, 0);
    repeat (1000) step(1, 0);
    // PRBS-15, single injected error once locked
    prbs_sel = 1; gsel = 1;
    gen_seed(15'h4A3D);
    pulse_rst_prbs(1);
    repeat (200) step(1, 0);
    step(1, 1);
    repeat (100) step(1, 0);
    // burst of errors until the checker loses sync, then clean relock
    for (int i = 0; i < 64 && ph == 2; i++) step(1, i % 2 == 0);
    repeat (200) step(1, 0);
    // PRBS-7 with valid toggling every cycle
    prbs_sel = 0; gsel = 0;
    gen_seed(15'h007F);
    pulse_rst_prbs(0);
    repeat (300) begin step(1, 0); step(0, 0); end
    // sparse errors across several windows saturate the narrow error counter
    for (int i = 0; i < 250; i++) step(1, i % 10 == 0);
    pulse_rst_prbs(1);
    repeat (120) step(1, 0);
    // randomized traffic with occasional enable, select and clear events
    repeat (800) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      if ($urandom_range(0, 249) == 0) begin
        prbs_sel = ~prbs_sel; gsel = prbs_sel;
        gen_seed(15'($urandom_range(1, 32767)) | 15'h1);
      end
      rst_prbs = $urandom_range(0, 299) == 0;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 2);
    end
    rst_prbs = 0; en = 1;
    repeat (200) step(1, 0);
    // one-cycle reset while checking
    rst_n = 0;
    step(1, 0);
    rst_n = 1;
    repeat (150) step(1, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
